lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, max cycles spent in REQ+RSP before the access is abandoned.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rd_en  input  1  load request from the controller.
REQ-005 wr_en  input  1  store request from the controller.
REQ-006 addr  input  32  byte address from the ALU result.
REQ-007 mem_acc_mode  input  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 store_data  input  32  store operand (rs2 value), right-aligned.
REQ-009 rdata  output  32  extended load result, to the writeback mux.
REQ-010 stall  output  1  holds the PC and register-file write while an access is in flight.
REQ-011 lsu_err  output  1  one-cycle pulse when an access is abandoned (timeout or misalign).
REQ-012 bus_req_valid / bus_req_ready  output / input  1 / 1  request handshake.
REQ-013 bus_addr  output  32  word-aligned address, addr[31:2],2'b00.
REQ-014 bus_we  output  1  1 = write.
REQ-015 bus_be  output  4  byte enables.
REQ-016 bus_wdata  output  32  lane-replicated store data.
REQ-017 bus_rsp_valid / bus_rsp_data  input / input  1 / 32  response; every request, including writes, gets exactly one response.

Function
REQ-018 FSM states are IDLE, REQ, RSP and DONE.
REQ-019 IDLE with rd_en|wr_en moves to REQ; stall is asserted combinationally in that same cycle.
REQ-020 When rd_en and wr_en are both high, the access is a store.
REQ-021 REQ latches addr, mode, we, be and wdata on entry; bus_req_valid is high and these fields are stable until bus_req_ready is sampled high.
REQ-022 REQ moves to RSP on the cycle bus_req_ready is sampled high.
REQ-023 RSP moves to DONE on bus_rsp_valid; on a load, rdata is registered from bus_rsp_data at that edge.
REQ-024 DONE lasts exactly one cycle with stall=0, then returns to IDLE; the next request is not accepted before IDLE.
REQ-025 stall=1 in IDLE-with-request, REQ and RSP; stall=0 otherwise.
REQ-026 Load extraction: B/BU take lane addr[1:0]; H/HU take lane addr[1]; W takes the full word. B and H sign-extend; BU and HU zero-extend.
REQ-027 Store lanes: B gives be=0001<<addr[1:0] with the byte replicated x4; H gives be=0011<<{addr[1],0} with the half replicated x2; W gives be=1111.
REQ-028 Loads drive be=1111.
REQ-029 rdata holds its last value outside load completion.
REQ-030 A saturating counter clears on entry to REQ and increments in REQ and RSP; at TIMEOUT_CYCLES it forces DONE with lsu_err=1, rdata=0 and bus_req_valid dropped.
REQ-031 bus_rsp_valid is ignored in IDLE, REQ and DONE.
REQ-032 An undefined mem_acc_mode (011, 110, 111) is treated as W.

Reset
REQ-033 Reset forces IDLE, stall=0, rdata=0, lsu_err=0, bus_req_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, counter=0.
REQ-034 Reset asserted mid-access abandons the access with no error pulse; a late response after reset is ignored.

Configuration
REQ-035 Macro LSU_MISALIGN_CHK_EN enables the misalignment check.
REQ-036 When defined, H/HU with addr[0]=1, or W with addr[1:0]!=0, goes IDLE->DONE with no bus request, lsu_err=1, rdata=0, and stall=1 for the request cycle only.
REQ-037 When undefined, no misalignment check exists: W ignores addr[1:0] and H ignores addr[0].

Structure
REQ-038 Package lsu_pkg holds the mem_acc_mode enum (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU) and the state enum.
REQ-039 Combinational sub-module lsu_align holds byte-enable generation, store replication and load extract/extend; lsu instantiates it.

Verification
REQ-040 Load, mode 000, addr 0x103, rsp 0x80FF_FF12 with ready in the request cycle: rdata=0xFFFF_FF80 in DONE; stall high for exactly 3 cycles.
REQ-041 Store, mode 001, addr 0x202, store_data 0x1234_ABCD: bus_addr=0x200, be=1100, wdata=0xABCD_ABCD, we=1.
REQ-042 bus_req_ready held low 5 cycles: request fields stable throughout; rdata/stall complete after ready and the response.
REQ-043 No response, TIMEOUT_CYCLES=8: lsu_err pulses once, rdata=0, stall drops, FSM returns to IDLE.
REQ-044 rst pulsed in RSP followed by a late bus_rsp_valid: FSM stays IDLE, rdata=0, no lsu_err.
REQ-045 With LSU_MISALIGN_CHK_EN, LW at 0x101: no bus_req_valid, lsu_err=1. Without the macro, the same access reads 0x100.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types and helpers for the load/store unit.
//
// Contents:
//   mem_acc_mode_e : funct3 access-size codes (B, H, W, BU, HU)
//   lsu_state_e    : access FSM states (IDLE, REQ, RSP, DONE)
//   decodeMode     : maps a raw funct3 onto mem_acc_mode_e; any undefined code
//                    is treated as a full-word access
//   isMisaligned   : true when a halfword or word access is not naturally aligned
//                    (only used when LSU_MISALIGN_CHK_EN is defined)

package lsu_pkg;

   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_acc_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   // Undefined codes (011, 110, 111) fall back to a plain word access so the
   // rest of the datapath only ever sees the five legal sizes.
   function automatic mem_acc_mode_e decodeMode(input logic [2:0] code);
      mem_acc_mode_e mode;
      case (code)
         3'b000:  mode = MEM_B;
         3'b001:  mode = MEM_H;
         3'b100:  mode = MEM_BU;
         3'b101:  mode = MEM_HU;
         default: mode = MEM_W;
      endcase
      return mode;
   endfunction

   // Byte accesses can never be misaligned; halfwords need addr[0]=0 and
   // words need addr[1:0]=0.
   function automatic logic isMisaligned(input mem_acc_mode_e mode,
                                         input logic [1:0] addrLo);
      logic bad;
      case (mode)
         MEM_H, MEM_HU: bad = addrLo[0];
         MEM_W:         bad = (addrLo != 2'b00);
         default:       bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- purely combinational lane logic for the load/store unit.
//
// Ports:
//   addrLo_i    : byte offset within the word (addr[1:0])
//   mode_i      : decoded access size
//   isStore_i   : 1 selects store byte enables, 0 gives the load enables (1111)
//   storeData_i : right-aligned store operand
//   loadWord_i  : raw 32-bit word returned by the bus
//   be_o        : byte enables for the bus
//   wdata_o     : store data replicated across every lane it may land in
//   loadData_o  : extracted and sign/zero-extended load result
//
// Halfword lanes are chosen by addrLo_i[1] only and words ignore addrLo_i,
// which is what the unit relies on when misalignment checking is disabled.

module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]    addrLo_i,
   input  mem_acc_mode_e mode_i,
   input  logic          isStore_i,
   input  logic [31:0]   storeData_i,
   input  logic [31:0]   loadWord_i,
   output logic [3:0]    be_o,
   output logic [31:0]   wdata_o,
   output logic [31:0]   loadData_o
);

   logic [7:0]  loadByte;
   logic [15:0] loadHalf;

   // Store side: loads always enable the full word; stores shift a one- or
   // two-byte enable into place and replicate the operand so the memory can
   // pick up the right lane without a barrel shifter of its own.
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = storeData_i;
      if (isStore_i) begin
         case (mode_i)
            MEM_B, MEM_BU: begin
               be_o    = 4'b0001 << addrLo_i;
               wdata_o = {4{storeData_i[7:0]}};
            end
            MEM_H, MEM_HU: begin
               be_o    = 4'b0011 << {addrLo_i[1], 1'b0};
               wdata_o = {2{storeData_i[15:0]}};
            end
            default: begin
               be_o    = 4'b1111;
               wdata_o = storeData_i;
            end
         endcase
      end
   end

   // Load side: pick the addressed byte/half out of the returned word, then
   // sign-extend for B/H and zero-extend for BU/HU.
   always_comb begin
      loadByte   = loadWord_i[{addrLo_i, 3'b000} +: 8];
      loadHalf   = addrLo_i[1] ? loadWord_i[31:16] : loadWord_i[15:0];
      loadData_o = loadWord_i;
      case (mode_i)
         MEM_B:   loadData_o = {{24{loadByte[7]}}, loadByte};
         MEM_BU:  loadData_o = {24'h000000, loadByte};
         MEM_H:   loadData_o = {{16{loadHalf[15]}}, loadHalf};
         MEM_HU:  loadData_o = {16'h0000, loadHalf};
         default: loadData_o = loadWord_i;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// lsu -- load/store unit sitting between the core pipeline and a simple
// valid/ready request + valid response data bus.
//
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in REQ+RSP before the access is abandoned
//
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   rd_en, wr_en        : load / store request (both high means store)
//   addr                : byte address
//   mem_acc_mode        : funct3 size code
//   store_data          : right-aligned store operand
//   rdata               : extended load result (held between loads)
//   stall               : freezes the pipeline while an access is in flight
//   lsu_err             : one-cycle pulse when an access is abandoned
//   bus_req_valid/ready : request handshake
//   bus_addr, bus_we, bus_be, bus_wdata : request fields, stable during REQ
//   bus_rsp_valid/data  : one response per request, only accepted in RSP
//
// Configuration:
//   LSU_MISALIGN_CHK_EN : when defined, misaligned H/HU/W accesses skip the
//                         bus entirely and finish with lsu_err and rdata=0.

module lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] addr,
   input  logic [2:0]  mem_acc_mode,
   input  logic [31:0] store_data,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        lsu_err,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rsp_data
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

   lsu_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]    addr_q, addr_d;
   mem_acc_mode_e  mode_q, mode_d;
   logic           we_q, we_d;
   logic [3:0]     be_q, be_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           err_q, err_d;

   logic           accessReq;
   mem_acc_mode_e  reqMode;
   logic           misaligned;
   logic           timeoutHit;
   logic [CNT_W-1:0] cntInc;

   logic [1:0]     alignAddrLo;
   mem_acc_mode_e  alignMode;
   logic           alignIsStore;
   logic [3:0]     alignBe;
   logic [31:0]    alignWdata;
   logic [31:0]    alignLoad;

   assign accessReq = rd_en | wr_en;
   assign reqMode   = decodeMode(mem_acc_mode);

`ifdef LSU_MISALIGN_CHK_EN
   assign misaligned = isMisaligned(reqMode, addr[1:0]);
`else
   assign misaligned = 1'b0;
`endif

   // The counter value on the last allowed cycle ends the access; it also
   // saturates so it can never wrap while the FSM sits in REQ or RSP.
   assign timeoutHit = (cnt_q >= CNT_LAST);
   assign cntInc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

   // One lane-logic instance serves both directions: in IDLE it sees the live
   // request so be/wdata can be captured on entry to REQ, afterwards it sees
   // the latched address/mode so the response can be extracted in RSP.
   assign alignAddrLo  = (state_q == IDLE) ? addr[1:0] : addr_q[1:0];
   assign alignMode    = (state_q == IDLE) ? reqMode   : mode_q;
   assign alignIsStore = (state_q == IDLE) ? wr_en     : we_q;

   lsu_align u_align (
      .addrLo_i    (alignAddrLo),
      .mode_i      (alignMode),
      .isStore_i   (alignIsStore),
      .storeData_i (store_data),
      .loadWord_i  (bus_rsp_data),
      .be_o        (alignBe),
      .wdata_o     (alignWdata),
      .loadData_o  (alignLoad)
   );

   // State and datapath registers. Reset clears every bus field so the bus
   // sees a quiet interface, and abandons any access without an error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         mode_q  <= MEM_B;
         we_q    <= 1'b0;
         be_q    <= 4'b0000;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         mode_q  <= mode_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Next-state and output logic. stall covers the request cycle in IDLE so
   // the pipeline freezes immediately, and stays up through REQ and RSP.
   // In REQ a timeout wins over ready, and bus_req_valid is withdrawn on that
   // cycle so no handshake can complete for an abandoned access. In RSP a
   // response arriving on the final cycle still completes normally.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      mode_d        = mode_q;
      we_d          = we_q;
      be_d          = be_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      err_d         = 1'b0;
      stall         = 1'b0;
      bus_req_valid = 1'b0;

      case (state_q)
         IDLE: begin
            if (accessReq) begin
               stall = 1'b1;
               if (misaligned) begin
                  state_d = DONE;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
                  addr_d  = addr;
                  mode_d  = reqMode;
                  we_d    = wr_en;
                  be_d    = alignBe;
                  wdata_d = alignWdata;
               end
            end
         end

         REQ: begin
            stall = 1'b1;
            if (timeoutHit) begin
               state_d = DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               bus_req_valid = 1'b1;
               cnt_d         = cntInc;
               if (bus_req_ready) begin
                  state_d = RSP;
               end
            end
         end

         RSP: begin
            stall = 1'b1;
            if (bus_rsp_valid) begin
               state_d = DONE;
               if (!we_q) begin
                  rdata_d = alignLoad;
               end
            end else if (timeoutHit) begin
               state_d = DONE;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cntInc;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rdata     = rdata_q;
   assign lsu_err   = err_q;
   assign bus_addr  = {addr_q[31:2], 2'b00};
   assign bus_we    = we_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- directed self-checking bench for the load/store unit.
// The DUT is built with TIMEOUT_CYCLES=8 so the timeout path is short.
// Inputs are driven on the falling edge and outputs sampled 1ns later.

module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [31:0] addr;
   logic [2:0]  mem_acc_mode;
   logic [31:0] store_data;
   logic [31:0] rdata;
   logic        stall, lsu_err;
   logic        bus_req_valid, bus_req_ready;
   logic [31:0] bus_addr;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_rsp_valid;
   logic [31:0] bus_rsp_data;

   int checks = 0;
   int errors = 0;

   // Observations captured by applyStimulus for one access.
   int          obsStall;
   int          obsValid;
   int          obsErr;
   logic [31:0] obsAddr;
   logic [3:0]  obsBe;
   logic [31:0] obsWdata;
   logic        obsWe;
   bit          obsStable;
   logic [31:0] obsRdata;
   bit          obsFinished;

   lsu #(.TIMEOUT_CYCLES(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .rd_en         (rd_en),
      .wr_en         (wr_en),
      .addr          (addr),
      .mem_acc_mode  (mem_acc_mode),
      .store_data    (store_data),
      .rdata         (rdata),
      .stall         (stall),
      .lsu_err       (lsu_err),
      .bus_req_valid (bus_req_valid),
      .bus_req_ready (bus_req_ready),
      .bus_addr      (bus_addr),
      .bus_we        (bus_we),
      .bus_be        (bus_be),
      .bus_wdata     (bus_wdata),
      .bus_rsp_valid (bus_rsp_valid),
      .bus_rsp_data  (bus_rsp_data)
   );

   always #5 clk = ~clk;

   // Issues one access and plays the bus: ready is given after readyDelay
   // valid cycles, the response (if any) on the cycle after the handshake.
   // Runs until the DONE cycle (bounded), then two more idle cycles.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [2:0] m, input logic [31:0] sd,
                                input int readyDelay, input bit giveRsp,
                                input logic [31:0] rspData);
      bit rspNext = 0;
      obsStall = 0; obsValid = 0; obsErr = 0; obsStable = 1; obsFinished = 0;
      obsAddr = '0; obsBe = '0; obsWdata = '0; obsWe = 1'b0; obsRdata = 'x;
      @(negedge clk);
      rd_en = rd; wr_en = wr; addr = a; mem_acc_mode = m; store_data = sd;
      bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
      for (int cyc = 0; cyc < 40 && !obsFinished; cyc++) begin
         if (cyc > 0) begin
            @(negedge clk);
            rd_en = 1'b0; wr_en = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
            if (rspNext) begin
               bus_rsp_valid = giveRsp;
               bus_rsp_data  = rspData;
               rspNext       = 0;
            end
         end
         #1;
         if (lsu_err) obsErr++;
         if (stall) obsStall++;
         else if (cyc > 0) begin
            obsFinished = 1;
            obsRdata    = rdata;
         end
         if (bus_req_valid) begin
            if (obsValid == 0) begin
               obsAddr = bus_addr; obsBe = bus_be; obsWdata = bus_wdata; obsWe = bus_we;
            end else if (bus_addr !== obsAddr || bus_be !== obsBe ||
                         bus_wdata !== obsWdata || bus_we !== obsWe) begin
               obsStable = 0;
            end
            bus_req_ready = (obsValid == readyDelay);
            if (bus_req_ready) rspNext = 1;
            obsValid++;
         end
      end
      repeat (2) begin
         @(negedge clk);
         bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
         #1;
         if (lsu_err) obsErr++;
         if (stall) obsStall++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; mem_acc_mode = 3'b000;
      store_data = '0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_data = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if ({stall, lsu_err, bus_req_valid, bus_we} !== 4'b0000) begin
         errors++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {stall, lsu_err, bus_req_valid, bus_we});
      end
      checks++; if (rdata !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata);
      end
      checks++; if ({bus_addr, bus_wdata, bus_be} !== 68'h0) begin
         errors++; $display("[TB] FAIL reset_bus: addr %h wdata %h be %b expected all zero", bus_addr, bus_wdata, bus_be);
      end
      rst = 1'b0;
   endtask

   task automatic test_load_byte();
      applyStimulus(1'b1, 1'b0, 32'h0000_0103, 3'b000, 32'h0, 0, 1, 32'h80FF_FF12);
      checks++; if (!obsFinished || obsRdata !== 32'hFFFF_FF80) begin
         errors++; $display("[TB] FAIL lb_rdata: got %h expected ffffff80 (finished=%0d)", obsRdata, obsFinished);
      end
      checks++; if (obsStall !== 3) begin
         errors++; $display("[TB] FAIL lb_stall: got %0d cycles expected 3", obsStall);
      end
      checks++; if (obsAddr !== 32'h100 || obsBe !== 4'b1111 || obsWe !== 1'b0) begin
         errors++; $display("[TB] FAIL lb_bus: addr %h be %b we %b expected 00000100 1111 0", obsAddr, obsBe, obsWe);
      end
      checks++; if (obsErr !== 0) begin
         errors++; $display("[TB] FAIL lb_err: got %0d pulses expected 0", obsErr);
      end
   endtask

   task automatic test_store_half();
      applyStimulus(1'b0, 1'b1, 32'h0000_0202, 3'b001, 32'h1234_ABCD, 0, 1, 32'hDEAD_BEEF);
      checks++; if (obsAddr !== 32'h200 || obsBe !== 4'b1100 || obsWe !== 1'b1) begin
         errors++; $display("[TB] FAIL sh_bus: addr %h be %b we %b expected 00000200 1100 1", obsAddr, obsBe, obsWe);
      end
      checks++; if (obsWdata !== 32'hABCD_ABCD) begin
         errors++; $display("[TB] FAIL sh_wdata: got %h expected abcdabcd", obsWdata);
      end
      checks++; if (obsRdata !== 32'hFFFF_FF80 || obsStall !== 3) begin
         errors++; $display("[TB] FAIL sh_hold: rdata %h stall %0d expected ffffff80 3", obsRdata, obsStall);
      end
   endtask

   task automatic test_store_byte_both_enables();
      applyStimulus(1'b1, 1'b1, 32'h0000_0003, 3'b000, 32'h0000_00AB, 0, 1, 32'h0);
      checks++; if (obsBe !== 4'b1000 || obsWdata !== 32'hABAB_ABAB || obsWe !== 1'b1) begin
         errors++; $display("[TB] FAIL sb_bus: be %b wdata %h we %b expected 1000 abababab 1", obsBe, obsWdata, obsWe);
      end
   endtask

   task automatic test_ready_delay();
      applyStimulus(1'b1, 1'b0, 32'h0000_0300, 3'b010, 32'h0, 5, 1, 32'hCAFE_F00D);
      checks++; if (!obsStable || obsValid !== 6) begin
         errors++; $display("[TB] FAIL wait_stable: stable %0d valid cycles %0d expected 1 6", obsStable, obsValid);
      end
      checks++; if (obsRdata !== 32'hCAFE_F00D || obsStall !== 8) begin
         errors++; $display("[TB] FAIL wait_done: rdata %h stall %0d expected cafef00d 8", obsRdata, obsStall);
      end
   endtask

   task automatic test_load_extend();
      applyStimulus(1'b1, 1'b0, 32'h0000_0101, 3'b100, 32'h0, 0, 1, 32'h0000_8000);
      checks++; if (obsRdata !== 32'h0000_0080) begin
         errors++; $display("[TB] FAIL lbu: got %h expected 00000080", obsRdata);
      end
      applyStimulus(1'b1, 1'b0, 32'h0000_0102, 3'b001, 32'h0, 0, 1, 32'h8001_1234);
      checks++; if (obsRdata !== 32'hFFFF_8001) begin
         errors++; $display("[TB] FAIL lh: got %h expected ffff8001", obsRdata);
      end
      applyStimulus(1'b1, 1'b0, 32'h0000_0100, 3'b101, 32'h0, 0, 1, 32'h8001_F234);
      checks++; if (obsRdata !== 32'h0000_F234) begin
         errors++; $display("[TB] FAIL lhu: got %h expected 0000f234", obsRdata);
      end
      applyStimulus(1'b1, 1'b0, 32'h0000_0400, 3'b111, 32'h0, 0, 1, 32'h9876_5432);
      checks++; if (obsRdata !== 32'h9876_5432 || obsBe !== 4'b1111) begin
         errors++; $display("[TB] FAIL undef_mode: rdata %h be %b expected 98765432 1111", obsRdata, obsBe);
      end
   endtask

   task automatic test_timeout();
      applyStimulus(1'b1, 1'b0, 32'h0000_0500, 3'b010, 32'h0, 0, 0, 32'h0);
      checks++; if (obsErr !== 1) begin
         errors++; $display("[TB] FAIL to_err: got %0d pulses expected 1", obsErr);
      end
      checks++; if (!obsFinished || obsRdata !== 32'h0) begin
         errors++; $display("[TB] FAIL to_rdata: got %h expected 00000000 (finished=%0d)", obsRdata, obsFinished);
      end
      checks++; if (obsStall !== 9 || bus_req_valid !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("[TB] FAIL to_idle: stall cycles %0d valid %b stall %b expected 9 0 0", obsStall, bus_req_valid, stall);
      end
   endtask

   task automatic test_misalign();
      applyStimulus(1'b1, 1'b0, 32'h0000_0101, 3'b010, 32'h0, 0, 1, 32'h5555_AAAA);
`ifdef LSU_MISALIGN_CHK_EN
      checks++; if (obsValid !== 0 || obsErr !== 1 || obsStall !== 1) begin
         errors++; $display("[TB] FAIL misalign: valid %0d err %0d stall %0d expected 0 1 1", obsValid, obsErr, obsStall);
      end
      checks++; if (obsRdata !== 32'h0) begin
         errors++; $display("[TB] FAIL misalign_rdata: got %h expected 00000000", obsRdata);
      end
`else
      checks++; if (obsAddr !== 32'h100 || obsErr !== 0) begin
         errors++; $display("[TB] FAIL unaligned_lw: addr %h err %0d expected 00000100 0", obsAddr, obsErr);
      end
      checks++; if (obsRdata !== 32'h5555_AAAA) begin
         errors++; $display("[TB] FAIL unaligned_rdata: got %h expected 5555aaaa", obsRdata);
      end
`endif
   endtask

   task automatic test_reset_mid_access();
      int errSeen = 0;
      applyStimulus(1'b1, 1'b0, 32'h0000_0600, 3'b010, 32'h0, 0, 1, 32'h1357_2468);
      checks++; if (rdata !== 32'h1357_2468) begin
         errors++; $display("[TB] FAIL pre_reset_rdata: got %h expected 13572468", rdata);
      end
      @(negedge clk);
      rd_en = 1'b1; addr = 32'h0000_0700; mem_acc_mode = 3'b010; bus_req_ready = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
      bus_req_ready = 1'b0;
      #1;
      checks++; if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL in_rsp: stall %b valid %b expected 1 0", stall, bus_req_valid);
      end
      rst = 1'b1;
      #2;
      rst = 1'b0;
      @(negedge clk);
      bus_rsp_valid = 1'b1; bus_rsp_data = 32'hFFFF_FFFF;
      #1;
      if (lsu_err) errSeen++;
      repeat (2) begin
         @(negedge clk);
         bus_rsp_valid = 1'b0;
         #1;
         if (lsu_err) errSeen++;
      end
      checks++; if (stall !== 1'b0 || bus_req_valid !== 1'b0 || errSeen !== 0) begin
         errors++; $display("[TB] FAIL rst_abandon: stall %b valid %b err %0d expected 0 0 0", stall, bus_req_valid, errSeen);
      end
      checks++; if (rdata !== 32'h0) begin
         errors++; $display("[TB] FAIL rst_rdata: got %h expected 00000000", rdata);
      end
   endtask

   initial begin
      test_reset();
      test_load_byte();
      test_store_half();
      test_store_byte_both_enables();
      test_ready_delay();
      test_load_extend();
      test_timeout();
      test_misalign();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
